// File: rtl/memdep_vio_reporter_if.sv
// Violation-report bundle between the store-issue pipelines / predictor side and the
// memdep violation reporter.
//   master : drives the per-lane violation reports and flush, observes the serialised
//            report, the queue occupancy and the dropped-report counter.
//   slave  : the reporter itself.
// Signals:
//   i_vio_vld[lane], i_vio_store_foldpc[lane], i_vio_load_foldpc[lane], i_flush
//   o_violation, o_vio_store_foldpc, o_vio_load_foldpc, o_pending, o_drop_cnt
`ifndef STORE_ISSUE_WIDTH
`define STORE_ISSUE_WIDTH 2
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 8
`endif

interface memdep_vio_reporter_if #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
);
  logic [`STORE_ISSUE_WIDTH-1:0]   i_vio_vld;
  logic [`MEMDEP_FOLDPC_WIDTH-1:0] i_vio_store_foldpc [`STORE_ISSUE_WIDTH];
  logic [`MEMDEP_FOLDPC_WIDTH-1:0] i_vio_load_foldpc  [`STORE_ISSUE_WIDTH];
  logic                            i_flush;
  logic                            o_violation;
  logic [`MEMDEP_FOLDPC_WIDTH-1:0] o_vio_store_foldpc;
  logic [`MEMDEP_FOLDPC_WIDTH-1:0] o_vio_load_foldpc;
  logic [$clog2(DEPTH):0]          o_pending;
  logic [DROP_CNT_WIDTH-1:0]       o_drop_cnt;

  modport master (
    output i_vio_vld, i_vio_store_foldpc, i_vio_load_foldpc, i_flush,
    input  o_violation, o_vio_store_foldpc, o_vio_load_foldpc, o_pending, o_drop_cnt
  );

  modport slave (
    input  i_vio_vld, i_vio_store_foldpc, i_vio_load_foldpc, i_flush,
    output o_violation, o_vio_store_foldpc, o_vio_load_foldpc, o_pending, o_drop_cnt
  );
endinterface

// File: rtl/memdep_vio_reporter.sv
// Memory-order violation reporter.
// Collects {store, load} folded-PC violation pairs from all store-issue lanes, drops
// duplicates, buffers them in a small circular FIFO and serialises them to the store-set
// predictor at most once every two cycles (the predictor's SSIT update takes two cycles).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   vio  : memdep_vio_reporter_if.slave (lane reports + flush in; report pulse, report
//          pair, queue occupancy and saturating dropped-report count out)
`ifndef STORE_ISSUE_WIDTH
`define STORE_ISSUE_WIDTH 2
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 8
`endif

module memdep_vio_reporter #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  memdep_vio_reporter_if.slave vio
);
  localparam int unsigned W  = `STORE_ISSUE_WIDTH;
  localparam int unsigned FW = `MEMDEP_FOLDPC_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = DROP_CNT_WIDTH;

  localparam logic [PW-1:0] DepthP  = PW'(DEPTH);
  localparam logic [PW-1:0] PtrOne  = PW'(1);
  localparam logic [DW:0]   DropOne = (DW + 1)'(1);

  logic [FW-1:0] st_mem [DEPTH];
  logic [FW-1:0] ld_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  // The registered report pulse also serves as the cooldown: no pop while it is high.
  logic          vio_q, vio_d;
  logic [FW-1:0] out_st_q, out_st_d;
  logic [FW-1:0] out_ld_q, out_ld_d;
  logic [DW-1:0] drop_q, drop_d;

  logic [PW-1:0]    count;
  logic [PW-1:0]    free;
  logic [PW-1:0]    n_push;
  logic [DW:0]      n_drop;
  logic [DW:0]      drop_sum;
  logic             pop;
  logic             dup;
  logic [DEPTH-1:0] slot_vld;
  logic [W-1:0]     wr_en;
  logic [AW-1:0]    wr_idx [W];

  always_comb begin
    count    = tail_q - head_q;
    pop      = (count != '0) && !vio_q && !vio.i_flush;
    free     = DepthP - count + (pop ? PtrOne : '0);

    // Occupied slots, including the head being popped this cycle.
    slot_vld = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < count) begin
        slot_vld[AW'(head_q[AW-1:0] + AW'(k))] = 1'b1;
      end
    end

    n_push = '0;
    n_drop = '0;
    wr_en  = '0;
    dup    = 1'b0;
    for (int l = 0; l < W; l++) begin
      wr_idx[l] = '0;
    end

    for (int l = 0; l < W; l++) begin
      dup = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
        if (slot_vld[s] && (st_mem[s] == vio.i_vio_store_foldpc[l]) &&
            (ld_mem[s] == vio.i_vio_load_foldpc[l])) begin
          dup = 1'b1;
        end
      end
      for (int e = 0; e < W; e++) begin
        if ((e < l) && vio.i_vio_vld[e] &&
            (vio.i_vio_store_foldpc[e] == vio.i_vio_store_foldpc[l]) &&
            (vio.i_vio_load_foldpc[e] == vio.i_vio_load_foldpc[l])) begin
          dup = 1'b1;
        end
      end
      if (vio.i_vio_vld[l] && !vio.i_flush && !dup) begin
        if (n_push < free) begin
          wr_en[l]  = 1'b1;
          wr_idx[l] = AW'(tail_q[AW-1:0] + n_push[AW-1:0]);
          n_push    = n_push + PtrOne;
        end else begin
          n_drop = n_drop + DropOne;
        end
      end
    end

    drop_sum = {1'b0, drop_q} + n_drop;
    drop_d   = drop_sum[DW] ? '1 : drop_sum[DW-1:0];

    head_d   = head_q;
    tail_d   = tail_q;
    vio_d    = pop;
    out_st_d = out_st_q;
    out_ld_d = out_ld_q;
    if (vio.i_flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop) begin
        head_d   = head_q + PtrOne;
        out_st_d = st_mem[head_q[AW-1:0]];
        out_ld_d = ld_mem[head_q[AW-1:0]];
      end
      tail_d = tail_q + n_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      vio_q    <= 1'b0;
      out_st_q <= '0;
      out_ld_q <= '0;
      drop_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      vio_q    <= vio_d;
      out_st_q <= out_st_d;
      out_ld_q <= out_ld_d;
      drop_q   <= drop_d;
    end
  end

  // Payload storage needs no reset: slots are only read while the pointers mark them valid.
  always_ff @(posedge clk) begin
    for (int l = 0; l < W; l++) begin
      if (wr_en[l]) begin
        st_mem[wr_idx[l]] <= vio.i_vio_store_foldpc[l];
        ld_mem[wr_idx[l]] <= vio.i_vio_load_foldpc[l];
      end
    end
  end

  assign vio.o_violation        = vio_q;
  assign vio.o_vio_store_foldpc = out_st_q;
  assign vio.o_vio_load_foldpc  = out_ld_q;
  assign vio.o_pending          = count;
  assign vio.o_drop_cnt         = drop_q;

endmodule

// File: tb/tb_memdep_vio_reporter.sv
// Bench for memdep_vio_reporter: a per-cycle vector table (inputs, expected occupancy,
// pulse and drop counts) plus a scoreboard of expected report pairs consumed whenever the
// DUT pulses. A second instance with a 2-bit drop counter shares the stimulus.
`ifndef STORE_ISSUE_WIDTH
`define STORE_ISSUE_WIDTH 2
`endif
`ifndef MEMDEP_FOLDPC_WIDTH
`define MEMDEP_FOLDPC_WIDTH 8
`endif

module tb_memdep_vio_reporter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memdep_vio_reporter_if #(.DEPTH(4), .DROP_CNT_WIDTH(16)) vif ();
  memdep_vio_reporter_if #(.DEPTH(4), .DROP_CNT_WIDTH(2))  vif2 ();

  memdep_vio_reporter #(.DEPTH(4), .DROP_CNT_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .vio(vif)
  );

  memdep_vio_reporter #(.DEPTH(4), .DROP_CNT_WIDTH(2)) dut2 (
    .clk(clk),
    .rst(rst),
    .vio(vif2)
  );

  typedef struct {
    logic [1:0] vld;
    logic [7:0] s0, l0, s1, l1;
    logic       flush;
    logic [1:0] push;   // lanes expected to be enqueued
    int         pend;   // expected after the edge
    int         vio;
    int         drop;
    int         drop2;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic [7:0] l;
  } pair_t;

  vec_t  vecs [$];
  pair_t sb   [$];
  int    n_chk  = 0;
  int    n_fail = 0;
  logic  prev_vio = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void add(input logic [1:0] vld, input logic [7:0] s0, l0, s1, l1,
                              input logic flush, input logic [1:0] push,
                              input int pend, vio, drop, drop2);
    vec_t v;
    v.vld = vld; v.s0 = s0; v.l0 = l0; v.s1 = s1; v.l1 = l1; v.flush = flush;
    v.push = push; v.pend = pend; v.vio = vio; v.drop = drop; v.drop2 = drop2;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [1:0] vld, input logic [7:0] s0, l0, s1, l1,
                       input logic flush);
    vif.i_vio_vld              = vld;
    vif.i_vio_store_foldpc[0]  = s0;
    vif.i_vio_load_foldpc[0]   = l0;
    vif.i_vio_store_foldpc[1]  = s1;
    vif.i_vio_load_foldpc[1]   = l1;
    vif.i_flush                = flush;
    vif2.i_vio_vld             = vld;
    vif2.i_vio_store_foldpc[0] = s0;
    vif2.i_vio_load_foldpc[0]  = l0;
    vif2.i_vio_store_foldpc[1] = s1;
    vif2.i_vio_load_foldpc[1]  = l1;
    vif2.i_flush               = flush;
  endtask

  function automatic void sb_push(input logic [7:0] s, l);
    pair_t p;
    p.s = s;
    p.l = l;
    sb.push_back(p);
  endfunction

  // Pulse monitor: every pulse must match the oldest expected pair and never be adjacent
  // to another pulse.
  always @(negedge clk) begin
    pair_t p;
    if (vif.o_violation === 1'b1) begin
      check("no_adjacent_pulse", int'(prev_vio), 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        p = sb.pop_front();
        check("pulse_store_foldpc", int'(vif.o_vio_store_foldpc), int'(p.s));
        check("pulse_load_foldpc", int'(vif.o_vio_load_foldpc), int'(p.l));
      end
    end
    prev_vio = (vif.o_violation === 1'b1);
  end

  initial begin
    rst = 1'b1;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    //  vld    s0     l0     s1     l1   fl  push pend vio drop drop2
    // single report
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    add(2'b01, 8'h12, 8'h34, 8'h00, 8'h00, 0, 2'b01, 1, 0, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    // burst of four over two cycles
    add(2'b11, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2'b11, 2, 0, 0, 0);
    add(2'b11, 8'h07, 8'h08, 8'h09, 8'h0a, 0, 2'b11, 3, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 3, 0, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 2, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 2, 0, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 1, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 1, 0, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    // duplicates: same-cycle lanes, then against the queued entry
    add(2'b11, 8'h05, 8'h06, 8'h05, 8'h06, 0, 2'b01, 1, 0, 0, 0);
    add(2'b01, 8'h05, 8'h06, 8'h00, 8'h00, 0, 2'b00, 0, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    // re-report after emission is accepted
    add(2'b01, 8'h05, 8'h06, 8'h00, 8'h00, 0, 2'b01, 1, 0, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 1, 0, 0);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 0, 0);
    // fill, then overflow during cooldown (same store, different load is not a dup)
    add(2'b11, 8'h11, 8'h21, 8'h11, 8'h22, 0, 2'b11, 2, 0, 0, 0);
    add(2'b11, 8'h13, 8'h23, 8'h14, 8'h24, 0, 2'b11, 3, 1, 0, 0);
    add(2'b01, 8'h15, 8'h25, 8'h00, 8'h00, 0, 2'b01, 4, 0, 0, 0);
    add(2'b01, 8'h16, 8'h26, 8'h00, 8'h00, 0, 2'b01, 4, 1, 0, 0);
    add(2'b11, 8'h17, 8'h27, 8'h18, 8'h28, 0, 2'b00, 4, 0, 2, 2);
    add(2'b11, 8'h19, 8'h29, 8'h1a, 8'h2a, 0, 2'b01, 4, 1, 3, 3);
    add(2'b11, 8'h1b, 8'h2b, 8'h1c, 8'h2c, 0, 2'b00, 4, 0, 5, 3);
    // flush with a report in flight, then flush while a pop is due
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 3, 1, 5, 3);
    add(2'b01, 8'h3a, 8'h3b, 8'h00, 8'h00, 1, 2'b00, 0, 0, 5, 3);
    add(2'b11, 8'h41, 8'h42, 8'h43, 8'h44, 0, 2'b11, 2, 0, 5, 3);
    add(2'b01, 8'h45, 8'h46, 8'h00, 8'h00, 1, 2'b00, 0, 0, 5, 3);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 5, 3);
    add(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 0, 0, 5, 3);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_violation", int'(vif.o_violation), 0);
    check("rst_store_foldpc", int'(vif.o_vio_store_foldpc), 0);
    check("rst_load_foldpc", int'(vif.o_vio_load_foldpc), 0);
    check("rst_pending", int'(vif.o_pending), 0);
    check("rst_drop_cnt", int'(vif.o_drop_cnt), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].vld, vecs[i].s0, vecs[i].l0, vecs[i].s1, vecs[i].l1, vecs[i].flush);
      if (vecs[i].push[0]) sb_push(vecs[i].s0, vecs[i].l0);
      if (vecs[i].push[1]) sb_push(vecs[i].s1, vecs[i].l1);
      @(posedge clk);
      #1;
      // Pairs still queued in the DUT are gone; the in-flight one was already consumed.
      if (vecs[i].flush) sb.delete();
      check($sformatf("v%0d_pending", i), int'(vif.o_pending), vecs[i].pend);
      check($sformatf("v%0d_violation", i), int'(vif.o_violation), vecs[i].vio);
      check($sformatf("v%0d_drop_cnt", i), int'(vif.o_drop_cnt), vecs[i].drop);
      check($sformatf("v%0d_drop_cnt_w2", i), int'(vif2.o_drop_cnt), vecs[i].drop2);
    end

    // Outputs hold the last emitted pair (0x14/0x24) while idle.
    check("hold_store_foldpc", int'(vif.o_vio_store_foldpc), 'h14);
    check("hold_load_foldpc", int'(vif.o_vio_load_foldpc), 'h24);

    // Reset in the cycle a pop is due.
    drive(2'b11, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_pending", int'(vif.o_pending), 2);
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_violation", int'(vif.o_violation), 0);
    check("mid_rst_store_foldpc", int'(vif.o_vio_store_foldpc), 0);
    check("mid_rst_load_foldpc", int'(vif.o_vio_load_foldpc), 0);
    check("mid_rst_pending", int'(vif.o_pending), 0);
    check("mid_rst_drop_cnt", int'(vif.o_drop_cnt), 0);
    check("mid_rst_drop_cnt_w2", int'(vif2.o_drop_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_idle%0d_violation", i), int'(vif.o_violation), 0);
    end

    // Normal operation resumes after reset.
    drive(2'b01, 8'h61, 8'h62, 8'h00, 8'h00, 1'b0);
    sb_push(8'h61, 8'h62);
    @(posedge clk);
    #1;
    drive(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    check("resume_pending", int'(vif.o_pending), 1);
    @(posedge clk);
    #1;
    check("resume_violation", int'(vif.o_violation), 1);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
